// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller:
// exception codes, stall vectors and FSM states.
package pipe_ctrl_pkg;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Exception codes carried from the MEM stage
    localparam logic [3:0] EXC_NONE = 4'h0;
    localparam logic [3:0] EXC_INT  = 4'h1;
    localparam logic [3:0] EXC_RI   = 4'ha;
    localparam logic [3:0] EXC_OV   = 4'hc;
    localparam logic [3:0] EXC_SYS  = 4'hd;
    localparam logic [3:0] EXC_ERET = 4'he;

    // Stall vectors {wb,mem,ex,id,if,pc}
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Redirect target for a committed exception code
    function automatic logic [31:0] exc_target(
        input logic [3:0]  code,
        input logic [31:0] epc,
        input logic [31:0] exc_vec,
        input logic [31:0] ri_vec
    );
        logic [31:0] t;
        case (code)
            EXC_RI:   t = ri_vec;
            EXC_ERET: t = epc;
            default:  t = exc_vec;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_arb.sv
// Stall request priority encoder and
// runaway-stall watchdog.
module pipe_ctrl_stall_arb
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stallreq_if_i,
    input  logic       stallreq_id_i,
    input  logic       stallreq_ex_i,
    input  logic       stallreq_mem_i,
    input  logic       flush_i,
    output logic [5:0] stall_o,
    output logic       wdog_err_o
);

    logic [5:0] stall_raw;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       wdog_q, wdog_d;

    // Deepest requesting stage wins; a flush overrides any stall
    always_comb begin
        stall_raw = STALL_NONE;
        if (stallreq_mem_i)
            stall_raw = STALL_MEM;
        else if (stallreq_ex_i)
            stall_raw = STALL_EX;
        else if (stallreq_id_i)
            stall_raw = STALL_ID;
        else if (stallreq_if_i)
            stall_raw = STALL_IF;
        stall_o = flush_i ? STALL_NONE : stall_raw;
    end

    // Saturating consecutive-stall counter and sticky trip flag
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o == STALL_NONE)
            stall_cnt_d = 8'd0;
        else if (stall_cnt_q != 8'hff)
            stall_cnt_d = stall_cnt_q + 8'd1;
        wdog_d = wdog_q | (stall_cnt_q == 8'(STALL_LIMIT));
    end

    // Watchdog state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 8'd0;
            wdog_q      <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign wdog_err_o = wdog_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration plus
// exception / interrupt / eret flush sequencing.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC     = 32'h8000_0004,
    parameter logic [31:0] RI_VEC      = 32'h8000_0008,
    parameter int unsigned FLUSH_CYC   = 1,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic [3:0]  execode_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        int_pending,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        int_ack,
    output logic        wdog_err
);

    state_e      state_q;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic        int_ack_q;
    logic [1:0]  flush_cnt_q;

    logic        take_exc;
    logic        take_int;

    // Exceptions outrank interrupts; MEM stall defers both
    always_comb begin
        take_exc = !stallreq_mem && excp_valid
                   && (execode_i != EXC_NONE);
        take_int = !stallreq_mem && !excp_valid
                   && int_pending;
    end

    // Redirect FSM with registered flush, target and ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_q     <= 1'b0;
            new_pc_q    <= ZeroWord;
            int_ack_q   <= 1'b0;
            flush_cnt_q <= 2'd0;
        end else begin
            int_ack_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (take_exc) begin
                        state_q     <= ST_FLUSH;
                        flush_q     <= 1'b1;
                        flush_cnt_q <= 2'(FLUSH_CYC - 1);
                        new_pc_q    <= exc_target(execode_i, cp0_epc_i,
                                                  EXC_VEC, RI_VEC);
                    end else if (take_int) begin
                        state_q     <= ST_FLUSH;
                        flush_q     <= 1'b1;
                        flush_cnt_q <= 2'(FLUSH_CYC - 1);
                        new_pc_q    <= EXC_VEC;
                        int_ack_q   <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 2'd0) begin
                        state_q <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    pipe_ctrl_stall_arb #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .stallreq_if_i (stallreq_if),
        .stallreq_id_i (stallreq_id),
        .stallreq_ex_i (stallreq_ex),
        .stallreq_mem_i(stallreq_mem),
        .flush_i       (flush_q),
        .stall_o       (stall),
        .wdog_err_o    (wdog_err)
    );

    assign flush   = flush_q;
    assign new_pc  = new_pc_q;
    assign int_ack = int_ack_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table on a
// FLUSH_CYC=1 instance, hand sequences on FLUSH_CYC=3.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A (FLUSH_CYC = 1)
    logic        a_if, a_id, a_ex, a_mem, a_ev, a_ip;
    logic [3:0]  a_code;
    logic [31:0] a_epc;
    logic [5:0]  a_stall;
    logic        a_flush, a_ack, a_wdog;
    logic [31:0] a_pc;

    // Instance B (FLUSH_CYC = 3)
    logic        b_if, b_id, b_ex, b_mem, b_ev, b_ip;
    logic [3:0]  b_code;
    logic [31:0] b_epc;
    logic [5:0]  b_stall;
    logic        b_flush, b_ack, b_wdog;
    logic [31:0] b_pc;

    pipe_ctrl u_a (
        .clk(clk), .rst_n(rst_n),
        .stallreq_if(a_if), .stallreq_id(a_id),
        .stallreq_ex(a_ex), .stallreq_mem(a_mem),
        .excp_valid(a_ev), .execode_i(a_code),
        .cp0_epc_i(a_epc), .int_pending(a_ip),
        .stall(a_stall), .flush(a_flush),
        .new_pc(a_pc), .int_ack(a_ack),
        .wdog_err(a_wdog)
    );

    pipe_ctrl #(.FLUSH_CYC(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .stallreq_if(b_if), .stallreq_id(b_id),
        .stallreq_ex(b_ex), .stallreq_mem(b_mem),
        .excp_valid(b_ev), .execode_i(b_code),
        .cp0_epc_i(b_epc), .int_pending(b_ip),
        .stall(b_stall), .flush(b_flush),
        .new_pc(b_pc), .int_ack(b_ack),
        .wdog_err(b_wdog)
    );

    typedef struct {
        logic [3:0]  req;   // {mem,ex,id,if}
        logic        ev;
        logic [3:0]  code;
        logic [31:0] epc;
        logic        ip;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        ack;
    } vec_t;

    localparam int NV = 30;
    vec_t tv[NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    function automatic vec_t v(
        input logic [3:0] req, input logic ev,
        input logic [3:0] code, input logic [31:0] epc,
        input logic ip, input logic [5:0] st,
        input logic fl, input logic [31:0] pc,
        input logic ack);
        vec_t r;
        r.req = req; r.ev = ev; r.code = code;
        r.epc = epc; r.ip = ip; r.st = st;
        r.fl = fl; r.pc = pc; r.ack = ack;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        {a_mem, a_ex, a_id, a_if} = 4'b0;
        a_ev = 0; a_code = 0; a_epc = 0; a_ip = 0;
    endtask

    task automatic b_idle();
        {b_mem, b_ex, b_id, b_if} = 4'b0;
        b_ev = 0; b_code = 0; b_epc = 0; b_ip = 0;
    endtask

    localparam logic [31:0] EV = 32'h8000_0004;
    localparam logic [31:0] RV = 32'h8000_0008;
    localparam logic [31:0] EP = 32'hBFC0_0100;

    initial begin
        // Each row: inputs applied after an edge; stall is
        // checked against them, flush/new_pc/int_ack reflect
        // the previous edge.
        tv[0]  = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 0, 0,  0);
        tv[1]  = v(4'b0100, 0, 4'h0, 0,  0, 6'b001111, 0, 0,  0);
        tv[2]  = v(4'b0100, 0, 4'h0, 0,  0, 6'b001111, 0, 0,  0);
        tv[3]  = v(4'b0100, 0, 4'h0, 0,  0, 6'b001111, 0, 0,  0);
        tv[4]  = v(4'b0000, 1, 4'ha, 0,  0, 6'b000000, 0, 0,  0);
        tv[5]  = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 1, RV, 0);
        tv[6]  = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 0, RV, 0);
        tv[7]  = v(4'b1000, 1, 4'he, EP, 0, 6'b011111, 0, RV, 0);
        tv[8]  = v(4'b1000, 1, 4'he, EP, 0, 6'b011111, 0, RV, 0);
        tv[9]  = v(4'b0000, 1, 4'he, EP, 0, 6'b000000, 0, RV, 0);
        tv[10] = v(4'b0010, 0, 4'h0, 0,  0, 6'b000000, 1, EP, 0);
        tv[11] = v(4'b0010, 0, 4'h0, 0,  0, 6'b000111, 0, EP, 0);
        tv[12] = v(4'b0000, 1, 4'hd, 0,  1, 6'b000000, 0, EP, 0);
        tv[13] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 1, EV, 0);
        tv[14] = v(4'b0001, 0, 4'h0, 0,  0, 6'b000011, 0, EV, 0);
        tv[15] = v(4'b0000, 0, 4'h0, 0,  1, 6'b000000, 0, EV, 0);
        tv[16] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 1, EV, 1);
        tv[17] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 0, EV, 0);
        tv[18] = v(4'b0000, 1, 4'hc, 0,  0, 6'b000000, 0, EV, 0);
        tv[19] = v(4'b0000, 1, 4'ha, 0,  0, 6'b000000, 1, EV, 0);
        tv[20] = v(4'b0000, 1, 4'ha, 0,  0, 6'b000000, 0, EV, 0);
        tv[21] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 1, RV, 0);
        tv[22] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 0, RV, 0);
        tv[23] = v(4'b0000, 1, 4'h5, 0,  0, 6'b000000, 0, RV, 0);
        tv[24] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 1, EV, 0);
        tv[25] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 0, EV, 0);
        tv[26] = v(4'b0000, 1, 4'h0, 0,  1, 6'b000000, 0, EV, 0);
        tv[27] = v(4'b0000, 0, 4'h0, 0,  0, 6'b000000, 0, EV, 0);
        tv[28] = v(4'b1111, 0, 4'h0, 0,  0, 6'b011111, 0, EV, 0);
        tv[29] = v(4'b0110, 0, 4'h0, 0,  0, 6'b001111, 0, EV, 0);

        a_idle();
        b_idle();

        // Reset state
        #12;
        chk("rst_stall", 32'(a_stall), 0);
        chk("rst_flush", 32'(a_flush), 0);
        chk("rst_new_pc", a_pc, 0);
        chk("rst_int_ack", 32'(a_ack), 0);
        chk("rst_wdog", 32'(a_wdog), 0);
        rst_n = 1'b1;

        // Vector table on instance A
        for (int i = 0; i < NV; i++) begin
            tick();
            {a_mem, a_ex, a_id, a_if} = tv[i].req;
            a_ev = tv[i].ev; a_code = tv[i].code;
            a_epc = tv[i].epc; a_ip = tv[i].ip;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(tv[i].st));
            chk($sformatf("v%0d_flush", i), 32'(a_flush), 32'(tv[i].fl));
            chk($sformatf("v%0d_new_pc", i), a_pc, tv[i].pc);
            chk($sformatf("v%0d_int_ack", i), 32'(a_ack), 32'(tv[i].ack));
            chk($sformatf("v%0d_wdog", i), 32'(a_wdog), 0);
        end
        tick();
        a_idle();

        // Instance B: 3-cycle flush, second excp ignored
        b_ev = 1; b_code = 4'hc;
        #1;
        chk("b_pre_flush", 32'(b_flush), 0);
        tick();
        b_ev = 1; b_code = 4'ha; b_ex = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("b_flush_c%0d", c), 32'(b_flush), 1);
            chk($sformatf("b_pc_c%0d", c), b_pc, EV);
            chk($sformatf("b_stall_c%0d", c), 32'(b_stall), 0);
            tick();
        end
        b_idle();
        #1;
        chk("b_flush_end", 32'(b_flush), 0);
        tick();
        chk("b_no_second", 32'(b_flush), 0);
        chk("b_pc_kept", b_pc, EV);

        // Watchdog on instance A
        tick();
        a_if = 1;
        repeat (250) tick();
        chk("wdog_early", 32'(a_wdog), 0);
        repeat (10) tick();
        chk("wdog_trip", 32'(a_wdog), 1);
        a_if = 0;
        repeat (3) tick();
        chk("wdog_sticky", 32'(a_wdog), 1);
        chk("wdog_stall0", 32'(a_stall), 0);

        // Reset asserted mid-flush on instance B
        b_ev = 1; b_code = 4'hc;
        tick();
        b_idle();
        chk("b_mid_flush", 32'(b_flush), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flush", 32'(b_flush), 0);
        chk("rst_mid_pc", b_pc, 0);
        chk("rst_wdog_clr", 32'(a_wdog), 0);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rst_no_resume", 32'(b_flush), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
